// File: rtl/avalon_sysctrl_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of one single-port RAM: round-robin grant, master lock, 1-cycle read return.
// Grant is combinational this cycle; a losing or lock-excluded master sees waitrequest=1 until it is granted.
module avalon_sysctrl_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic                m0_lock,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic                m1_lock,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t state, state_nxt;
  logic   rr_last;
  logic   rv0, rv1;
  logic   req0, req1;
  logic   gnt0, gnt1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = state;
    if (!reset) begin
      case (state)
        IDLE: begin
          // rr_last names the master granted most recently; contention goes to the other one
          if (req0 && req1) begin
            gnt0 = rr_last;
            gnt1 = !rr_last;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
          if (gnt0 && m0_lock)
            state_nxt = LOCK0;
          else if (gnt1 && m1_lock)
            state_nxt = LOCK1;
        end
        LOCK0: begin
          gnt0 = req0;
          if (!m0_lock && (gnt0 || !req0))
            state_nxt = IDLE;
        end
        LOCK1: begin
          gnt1 = req1;
          if (!m1_lock && (gnt1 || !req1))
            state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rr_last <= 1'b1;
      rv0     <= 1'b0;
      rv1     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt0)
        rr_last <= 1'b0;
      else if (gnt1)
        rr_last <= 1'b1;
      // read+write together is a write, so no return is scheduled
      rv0 <= gnt0 & m0_read & ~m0_write;
      rv1 <= gnt1 & m1_read & ~m1_write;
    end
  end

  assign m0_waitrequest   = reset | (req0 & ~gnt0);
  assign m1_waitrequest   = reset | (req1 & ~gnt1);
  assign m0_readdatavalid = rv0 & ~reset;
  assign m1_readdatavalid = rv1 & ~reset;
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;

  assign mem_chipselect = gnt0 | gnt1;
  assign mem_write      = (gnt0 & m0_write) | (gnt1 & m1_write);
  assign mem_address    = gnt1 ? m1_address    : m0_address;
  assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
  assign mem_clken      = ~reset;

endmodule

// File: doc/avalon_sysctrl_mem_arbiter.md
AVALON_SYSCTRL_MEM_ARBITER -- requirements
Module: avalon_sysctrl_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, memory word-address width (256 words).
REQ-002 SHALL have parameter DATA_W, default 32, data width; byteenable width SHALL be DATA_W/8.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have, for each N in {0,1}, port mN_address  input  ADDR_W  master N word address.
REQ-006 SHALL have mN_read / mN_write  input  1 each  master N read/write request.
REQ-007 SHALL have mN_byteenable  input  DATA_W/8  and mN_writedata  input  DATA_W  master N write lanes/data.
REQ-008 SHALL have mN_lock  input  1  master N requests exclusive ownership across consecutive accesses.
REQ-009 SHALL have mN_waitrequest  output  1  master N request not accepted this cycle.
REQ-010 SHALL have mN_readdata  output  DATA_W  and mN_readdatavalid  output  1  read return to master N.
REQ-011 SHALL have mem_address  output  ADDR_W, mem_byteenable  output  DATA_W/8, mem_writedata  output  DATA_W  to the single-port RAM.
REQ-012 SHALL have mem_chipselect  output  1, mem_write  output  1, mem_clken  output  1  RAM controls.
REQ-013 SHALL have mem_readdata  input  DATA_W  RAM read data, valid one clk after address is presented.

Function
REQ-014 Request: reqN = mN_read | mN_write; at most one master SHALL be granted per cycle; grant is combinational from reqN and registered state.
REQ-015 Granted master: mN_waitrequest=0, mem_chipselect=1, mem_address/byteenable/writedata/write driven from master N; mem_write = mN_write.
REQ-016 Non-granted requesting master: mN_waitrequest=1; non-requesting master: mN_waitrequest=0 (don't-care to Avalon, fixed for checking).
REQ-017 No grant: mem_chipselect=0, mem_write=0, mem_address/byteenable/writedata hold master 0 values.
REQ-018 mem_clken SHALL be 1 except during reset, when 0.
REQ-019 FSM states IDLE, LOCK0, LOCK1; reset state IDLE.
REQ-020 IDLE: single requester granted; both requesting -> grant the master not granted last (round-robin pointer rr_last, 1 bit, updated on every grant).
REQ-021 IDLE -> LOCKn when master n is granted with mN_lock=1.
REQ-022 LOCKn: only master n may be granted; other master held with waitrequest=1 regardless of rr_last.
REQ-023 LOCKn -> IDLE when master n is granted with mN_lock=0, or when mN_lock=0 and reqN=0; otherwise stay.
REQ-024 Read latency: granted read at cycle T -> mN_readdatavalid=1 at T+1 for that master only, mN_readdata = mem_readdata at T+1; back-to-back reads SHALL return one per cycle in issue order, with no bubble on master switch.
REQ-025 mN_readdata SHALL equal mem_readdata at all times (routing by readdatavalid only).
REQ-026 mN_read and mN_write both high: treated as write; no readdatavalid generated.
REQ-027 Write granted at T SHALL update RAM at T edge; read of same address granted at T+1 SHALL return new data.
REQ-028 Zero bubbles: with both masters continuously requesting and no lock, grants SHALL alternate every cycle.

Reset
REQ-029 While reset=1: state IDLE, rr_last=1 (master 0 wins first contention), m0/m1_readdatavalid=0, m0/m1_waitrequest=1, mem_chipselect=0, mem_write=0.
REQ-030 Reset asserted mid-read: pending readdatavalid SHALL be dropped (0 in cycle after reset edge); lock released.
REQ-031 First grant possible in the first cycle after reset deasserts.

Verification
REQ-032 Both masters read same cycle after reset, addrs 0x10/0x20 -> m0 granted cycle 0, m1 cycle 1; m0_readdatavalid cycle 1, m1_readdatavalid cycle 2, correct data.
REQ-033 m1 writes 0xDEADBEEF to 0x05, byteenable 0x3, then reads 0x05 -> upper bytes unchanged, lower 16 bits 0xBEEF, readdatavalid one cycle after read grant.
REQ-034 m0 lock=1 for 4 writes while m1 reads continuously -> m1_waitrequest=1 for all 4, m1 granted cycle after m0's lock=0 access.
REQ-035 Both continuously reading 8 cycles -> grants alternate m0,m1,...; exactly 4 readdatavalid pulses each, no gaps on mem_chipselect.
REQ-036 Reset asserted the cycle after m0 read grant -> m0_readdatavalid stays 0, outputs at REQ-029 values, m0 granted first after release.
REQ-037 m0 read and write both high to 0x7F -> RAM written, m0_readdatavalid remains 0.
